dic_status_tx: RTL and testbench
================================

# dic_status_tx

Status-line transmitter for the digital clock. It is the outbound counterpart of the command-decoding clock FSM: that FSM turns received characters into clock/alarm state, and this block turns clock/alarm state back into a fixed-format ASCII line for the UART transmitter. On each refresh request it snapshots the displayed time digits, digit-enable flags and alarm display characters. It then streams one 14-character frame over a valid/ready byte handshake.

## Interface
Parameters:
- FRAME_LEN, 14, characters per frame; fixed, not user-changeable.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- refresh  input  1  one-cycle request to emit a frame.
- di_Mtens, di_Mones, di_Stens, di_Sones  input  4 each  current time digits (BCD).
- dicDspMtens, dicDspMones, dicDspStens, dicDspSones  input  1 each  digit display enables.
- A1LocalOutput … A6LocalOutput  input  8 each  alarm display characters (ASCII).
- tx_data  output  8  character to transmit.
- tx_valid  output  1  tx_data holds a valid character.
- tx_ready  input  1  UART transmitter accepts tx_data this cycle.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse after the last character is accepted.

## Operation
- Frame order, index 0..13: the following characters are sent in this sequence.
  - Mtens, Mones, ':', Stens, Sones, ' ' (space).
  - A1, A2, A3, A4, A5, A6.
  - 8'h0D, 8'h0A.
- Digit characters:
  - Enable high: "0" + digit.
  - Enable low: ' ' (8'h20).
  - Digit value > 9: '?' (8'h3F), regardless of the enable.
- Alarm characters are sent verbatim.
- Snapshot:
  - All digit, enable and alarm inputs are registered on the cycle the frame starts.
  - Input changes during a frame do not affect that frame; there is no tearing.
- States:
  - IDLE: tx_valid=0, busy=0. On refresh: take the snapshot, set index=0, go to SEND.
  - SEND: tx_valid=1, tx_data=char[index].
    - When tx_valid&&tx_ready: index increments.
    - When the accepted index is 13: go to DONE.
    - tx_data and tx_valid are held stable while tx_ready=0.
  - DONE: one cycle; frame_done=1, tx_valid=0.
    - If pending=1: clear pending, take a new snapshot, index=0, go to SEND.
    - Otherwise: go to IDLE.
- Pending request:
  - refresh in SEND or DONE sets a 1-deep pending flag.
  - Further refreshes while pending=1 are dropped.
  - refresh in DONE while pending=0 sets pending, so the next frame starts from DONE.
- busy=1 in SEND and DONE.
- Index counter: 4 bits, 0..13. It never wraps past 13.

## Timing
- Reset values: state=IDLE, index=0, pending=0, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, snapshot registers=0.
- Reset mid-frame:
  - Frame aborts; outputs take reset values on the next cycle.
  - No CR/LF is emitted and pending is cleared.
- rst has priority over refresh and tx_ready in the same cycle.
- Latency:
  - refresh at cycle N (in IDLE): tx_valid=1 with char 0 at cycle N+1.
  - Zero-stall frame (tx_ready held high): characters accepted at N+1..N+14, frame_done=1 at N+15, IDLE at N+16.
  - With a pending request: SEND resumes at N+16, i.e. one DONE bubble between frames.
- tx_ready while tx_valid=0 is ignored.
- Output drive: tx_data and tx_valid are registered (no combinational path from tx_ready); tx_data changes only on an accepted transfer or at frame start.

## Test plan
- Basic frame, ready always high:
  - Stimulus: digits 1,2,3,4, all enables=1, A1..A6="12:34@", refresh.
  - Required: "12:34 12:34@\r\n" on cycles N+1..N+14, frame_done at N+15.
- Blanking and invalid digit:
  - Stimulus: enables 1,0,0,0, digits 5,7,3,4, then a second frame with di_Sones=4'hC and its enable=1.
  - Required: first frame begins "5 : " then a trailing ' '; second frame sends '?' at index 4.
- Backpressure:
  - Stimulus: tx_ready toggles 1,0,0,1,… for the whole frame.
  - Required: each character is held stable while ready=0, no character is skipped or duplicated, 14 transfers total.
- Snapshot isolation and pending:
  - Stimulus: change digits at index 2 of a frame, and pulse refresh twice during that frame.
  - Required: the first frame carries the old values; exactly one follow-up frame starts after the DONE bubble and carries the new values.
- Reset mid-frame:
  - Stimulus: assert rst at index 7, with a pending request set.
  - Required: next cycle tx_valid=0, busy=0; no further characters; a refresh after reset starts a fresh frame at index 0.

Source files
------------

// File: rtl/dic_status_tx.sv
// dic_status_tx: streams a 14-char clock/alarm status line to a UART tx.
// Ports: clk, rst (sync, active-high), refresh, time digits + enables,
//   A1..A6 alarm chars, tx_data/tx_valid/tx_ready handshake,
//   busy (frame in progress), frame_done (1-cycle end pulse).
module dic_status_tx #(
  parameter int FRAME_LEN = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh,
  input  logic [3:0] di_Mtens,
  input  logic [3:0] di_Mones,
  input  logic [3:0] di_Stens,
  input  logic [3:0] di_Sones,
  input  logic       dicDspMtens,
  input  logic       dicDspMones,
  input  logic       dicDspStens,
  input  logic       dicDspSones,
  input  logic [7:0] A1LocalOutput,
  input  logic [7:0] A2LocalOutput,
  input  logic [7:0] A3LocalOutput,
  input  logic [7:0] A4LocalOutput,
  input  logic [7:0] A5LocalOutput,
  input  logic [7:0] A6LocalOutput,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic       pending;

  logic [7:0] sn_mt;
  logic [7:0] sn_mo;
  logic [7:0] sn_st;
  logic [7:0] sn_so;
  logic [7:0] sn_a1;
  logic [7:0] sn_a2;
  logic [7:0] sn_a3;
  logic [7:0] sn_a4;
  logic [7:0] sn_a5;
  logic [7:0] sn_a6;

  logic       load;
  logic [3:0] idx_nxt;
  logic [7:0] nxt_chr;
  logic [7:0] in_mt;
  logic [7:0] in_mo;
  logic [7:0] in_st;
  logic [7:0] in_so;

  function automatic logic [7:0] dig_chr(
    input logic [3:0] d,
    input logic       en
  );
    if (d > 4'd9)
      return 8'h3F;
    else if (en)
      return 8'h30 + {4'h0, d};
    else
      return 8'h20;
  endfunction

  // Digits are formatted on entry so the
  // snapshot holds ready-to-send chars.
  assign in_mt = dig_chr(di_Mtens, dicDspMtens);
  assign in_mo = dig_chr(di_Mones, dicDspMones);
  assign in_st = dig_chr(di_Stens, dicDspStens);
  assign in_so = dig_chr(di_Sones, dicDspSones);

  // A refresh seen in DONE counts as pending,
  // so back-to-back frames leave one bubble.
  assign load = ((state == S_IDLE) && refresh) ||
                ((state == S_DONE) && (pending || refresh));

  assign idx_nxt = idx + 4'd1;

  always_comb begin
    nxt_chr = 8'h00;
    case (idx_nxt)
      4'd1:    nxt_chr = sn_mo;
      4'd2:    nxt_chr = 8'h3A;
      4'd3:    nxt_chr = sn_st;
      4'd4:    nxt_chr = sn_so;
      4'd5:    nxt_chr = 8'h20;
      4'd6:    nxt_chr = sn_a1;
      4'd7:    nxt_chr = sn_a2;
      4'd8:    nxt_chr = sn_a3;
      4'd9:    nxt_chr = sn_a4;
      4'd10:   nxt_chr = sn_a5;
      4'd11:   nxt_chr = sn_a6;
      4'd12:   nxt_chr = 8'h0D;
      4'd13:   nxt_chr = 8'h0A;
      default: nxt_chr = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sn_mt <= 8'h00;
      sn_mo <= 8'h00;
      sn_st <= 8'h00;
      sn_so <= 8'h00;
      sn_a1 <= 8'h00;
      sn_a2 <= 8'h00;
      sn_a3 <= 8'h00;
      sn_a4 <= 8'h00;
      sn_a5 <= 8'h00;
      sn_a6 <= 8'h00;
    end else if (load) begin
      sn_mt <= in_mt;
      sn_mo <= in_mo;
      sn_st <= in_st;
      sn_so <= in_so;
      sn_a1 <= A1LocalOutput;
      sn_a2 <= A2LocalOutput;
      sn_a3 <= A3LocalOutput;
      sn_a4 <= A4LocalOutput;
      sn_a5 <= A5LocalOutput;
      sn_a6 <= A6LocalOutput;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      pending    <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (refresh) begin
            idx      <= 4'd0;
            tx_data  <= in_mt;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (refresh)
            pending <= 1'b1;
          if (tx_ready) begin
            if (idx == LAST) begin
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              idx     <= idx_nxt;
              tx_data <= nxt_chr;
            end
          end
        end
        S_DONE: begin
          if (pending || refresh) begin
            pending  <= 1'b0;
            idx      <= 4'd0;
            tx_data  <= in_mt;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dic_status_tx.sv
// tb_dic_status_tx: directed bench for dic_status_tx with a
// frame-level reference model checked every cycle.
module tb_dic_status_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       refresh;
  logic       tx_ready;
  logic [3:0] mt, mo, st, so;
  logic       emt, emo, est, eso;
  logic [7:0] a1, a2, a3, a4, a5, a6;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_done;

  dic_status_tx dut (
    .clk(clk), .rst(rst), .refresh(refresh),
    .di_Mtens(mt), .di_Mones(mo), .di_Stens(st), .di_Sones(so),
    .dicDspMtens(emt), .dicDspMones(emo),
    .dicDspStens(est), .dicDspSones(eso),
    .A1LocalOutput(a1), .A2LocalOutput(a2), .A3LocalOutput(a3),
    .A4LocalOutput(a4), .A5LocalOutput(a5), .A6LocalOutput(a6),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cnt_cmp = 0;
  int cnt_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  bit mon_en = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    cnt_cmp++;
    if (act !== exp) begin
      cnt_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dchr(logic [3:0] d, logic en);
    if (d > 4'd9) return "?";
    if (!en) return " ";
    return 8'(8'h30 + 8'(d));
  endfunction

  function automatic logic [111:0] frame_now();
    return {dchr(mt, emt), dchr(mo, emo), ":",
            dchr(st, est), dchr(so, eso), " ",
            a1, a2, a3, a4, a5, a6, 8'h0D, 8'h0A};
  endfunction

  // Frame-level model: the frame text in flight, how many
  // chars were taken, the end-of-frame bubble, a queued request.
  logic [111:0] m_frame = '0;
  int  m_idx = 0;
  bit  m_active = 0;
  bit  m_bubble = 0;
  bit  m_pend = 0;
  bit  prev_hold = 0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("tx_valid", 128'(tx_valid), 128'(m_active));
      chk("busy", 128'(busy), 128'(m_active || m_bubble));
      chk("frame_done", 128'(frame_done), 128'(m_bubble));
      if (m_active)
        chk("tx_data", 128'(tx_data),
            128'(m_frame[111 - 8*m_idx -: 8]));
      if (prev_hold)
        chk("hold", 128'({tx_valid, tx_data}),
            128'({1'b1, prev_data}));
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid && tx_ready && !rst) rx_q.push_back(tx_data);
      if (frame_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (rst) begin
        m_active = 0;
        m_bubble = 0;
        m_pend = 0;
        m_idx = 0;
        prev_hold = 0;
      end else if (m_active) begin
        if (refresh) m_pend = 1;
        if (tx_ready) begin
          m_idx++;
          if (m_idx == 14) begin
            m_active = 0;
            m_bubble = 1;
          end
        end
      end else if (m_bubble) begin
        m_bubble = 0;
        if (m_pend || refresh) begin
          m_frame = frame_now();
          m_idx = 0;
          m_active = 1;
          m_pend = 0;
        end
      end else if (refresh) begin
        m_frame = frame_now();
        m_idx = 0;
        m_active = 1;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    refresh = 1'b1;
    step(1);
    refresh = 1'b0;
  endtask

  task automatic set_dig(logic [15:0] d, logic [3:0] e);
    {mt, mo, st, so} = d;
    {emt, emo, est, eso} = e;
  endtask

  task automatic set_al(logic [47:0] s);
    {a1, a2, a3, a4, a5, a6} = s;
  endtask

  task automatic wait_frames(int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    if (done_cnt < target)
      chk("timeout_frame", 128'(done_cnt), 128'(target));
  endtask

  task automatic wait_rx(int target, int budget);
    int n = 0;
    while (rx_q.size() < target && n < budget) begin
      step(1);
      n++;
    end
    if (rx_q.size() < target)
      chk("timeout_rx", 128'(rx_q.size()), 128'(target));
  endtask

  task automatic chk_rx(string nm, int start, logic [111:0] exp);
    logic [111:0] got = '0;
    for (int i = 0; i < 14; i++) begin
      got = {got[103:0], 8'h00};
      if (start + i < rx_q.size()) got[7:0] = rx_q[start + i];
    end
    chk(nm, 128'(got), 128'(exp));
  endtask

  initial begin
    int rs, base, k0;
    logic [3:0] rdy_pat;
    rst = 1'b1;
    refresh = 1'b0;
    tx_ready = 1'b1;
    set_dig(16'h0000, 4'b0000);
    set_al(48'h0);
    step(1);
    mon_en = 1;
    step(1);
    chk("rst_data", 128'(tx_data), 128'(8'h00));
    chk("rst_valid", 128'(tx_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(frame_done), 128'(1'b0));
    rst = 1'b0;
    step(2);

    // basic frame, ready always high
    set_dig(16'h1234, 4'b1111);
    set_al("12:34@");
    rs = rx_q.size();
    k0 = cyc;
    pulse();
    wait_frames(1, 40);
    chk("latency_done", 128'(last_done_cyc - k0), 128'(15));
    chk_rx("basic", rs, "12:34 12:34@\r\n");
    step(2);

    // blanking, then invalid digit
    set_dig(16'h5734, 4'b1000);
    set_al("ABCDEF");
    rs = rx_q.size();
    pulse();
    wait_frames(2, 40);
    chk_rx("blank", rs, "5 :   ABCDEF\r\n");
    step(2);
    so = 4'hC;
    eso = 1'b1;
    rs = rx_q.size();
    pulse();
    wait_frames(3, 40);
    chk_rx("invalid", rs, "5 : ? ABCDEF\r\n");
    chk("idx4_q", 128'(rx_q[rs + 4]), 128'(8'h3F));
    step(2);

    // backpressure 1,0,0,1 repeating
    set_dig(16'h9009, 4'b1111);
    set_al("AL1 ON");
    rs = rx_q.size();
    rdy_pat = 4'b1001;
    pulse();
    for (int k = 0; k < 80 && done_cnt < 4; k++) begin
      tx_ready = rdy_pat[3 - (k % 4)];
      step(1);
    end
    tx_ready = 1'b1;
    chk("bp_done", 128'(done_cnt), 128'(4));
    chk("bp_count", 128'(rx_q.size() - rs), 128'(14));
    chk_rx("bp", rs, "90:09 AL1 ON\r\n");
    step(2);

    // snapshot isolation and one pending frame
    set_dig(16'h1059, 4'b1111);
    set_al("SNAP01");
    rs = rx_q.size();
    base = done_cnt;
    pulse();
    wait_rx(rs + 2, 20);
    set_dig(16'h2345, 4'b1111);
    set_al("NEWVAL");
    pulse();
    step(2);
    pulse();
    wait_frames(base + 2, 60);
    chk_rx("snap_old", rs, "10:59 SNAP01\r\n");
    chk_rx("snap_new", rs + 14, "23:45 NEWVAL\r\n");
    step(30);
    chk("no_third", 128'(done_cnt), 128'(base + 2));
    chk("snap_count", 128'(rx_q.size() - rs), 128'(28));

    // reset mid-frame with a pending request
    set_dig(16'h7777, 4'b1111);
    set_al("RESET!");
    rs = rx_q.size();
    base = done_cnt;
    pulse();
    step(1);
    pulse();
    wait_rx(rs + 7, 30);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_valid", 128'(tx_valid), 128'(1'b0));
    chk("rst_mid_busy", 128'(busy), 128'(1'b0));
    step(20);
    chk("rst_no_tx", 128'(rx_q.size()), 128'(rs + 7));
    chk("rst_no_done", 128'(done_cnt), 128'(base));
    set_dig(16'h0815, 4'b1111);
    set_al("FRESH1");
    rs = rx_q.size();
    pulse();
    wait_frames(base + 1, 40);
    chk_rx("fresh", rs, "08:15 FRESH1\r\n");
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cnt_cmp, cnt_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

endmodule
